// File: rtl/retire_stage.sv
// In-order retire stage: consumes the completed ROB head, commits its
// register write, and handles mispredict squash and halt.
module retire_stage #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = $clog2(ROB_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             head_valid,
    input  logic [TAG_W-1:0] head_tag,
    input  logic [4:0]       head_reg_idx,
    input  logic [31:0]      head_value,
    input  logic [31:0]      head_npc,
    input  logic             head_mispredict,
    input  logic             head_halt,
    output logic             retire_ack,
    output logic             mt_clear_en,
    output logic [4:0]       mt_clear_idx,
    output logic [TAG_W-1:0] mt_clear_tag,
    output logic             rf_wr_en,
    output logic [4:0]       rf_wr_idx,
    output logic [31:0]      rf_wr_data,
    output logic             squash,
    output logic [31:0]      redirect_pc,
    output logic             halted,
    output logic [31:0]      retired_count
);

    typedef enum logic [1:0] {RUN, SQUASH, HALTED} state_t;
    state_t state;

    logic retire;

    // Reset gates the handshake so the ROB never advances while reset is held.
    always_comb begin
        retire       = !reset && (state == RUN) && head_valid;
        retire_ack   = retire;
        mt_clear_en  = retire;
        mt_clear_idx = retire ? head_reg_idx : 5'd0;
        mt_clear_tag = retire ? head_tag : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            rf_wr_en      <= 1'b0;
            rf_wr_idx     <= 5'd0;
            rf_wr_data    <= 32'd0;
            squash        <= 1'b0;
            redirect_pc   <= 32'd0;
            halted        <= 1'b0;
            retired_count <= 32'd0;
        end else begin
            rf_wr_en <= 1'b0;
            squash   <= 1'b0;
            case (state)
                RUN: begin
                    if (head_valid) begin
                        rf_wr_en      <= (head_reg_idx != 5'd0);
                        rf_wr_idx     <= head_reg_idx;
                        rf_wr_data    <= head_value;
                        retired_count <= retired_count + 32'd1;
                        // Halt wins over a simultaneous mispredict.
                        if (head_halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else if (head_mispredict) begin
                            state       <= SQUASH;
                            squash      <= 1'b1;
                            redirect_pc <= head_npc;
                        end
                    end
                end
                SQUASH:  state <= RUN;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_retire_stage.sv
// Directed checks of retire_stage: retire, x0, mispredict, halt, wrap, async reset.
module tb_retire_stage;

    localparam int ROB_SIZE = 16;
    localparam int TAG_W    = $clog2(ROB_SIZE);

    logic             clock = 1'b0;
    logic             reset;
    logic             head_valid;
    logic [TAG_W-1:0] head_tag;
    logic [4:0]       head_reg_idx;
    logic [31:0]      head_value;
    logic [31:0]      head_npc;
    logic             head_mispredict;
    logic             head_halt;
    logic             retire_ack;
    logic             mt_clear_en;
    logic [4:0]       mt_clear_idx;
    logic [TAG_W-1:0] mt_clear_tag;
    logic             rf_wr_en;
    logic [4:0]       rf_wr_idx;
    logic [31:0]      rf_wr_data;
    logic             squash;
    logic [31:0]      redirect_pc;
    logic             halted;
    logic [31:0]      retired_count;

    int vectors = 0;
    int miscompares = 0;

    retire_stage #(.ROB_SIZE(ROB_SIZE)) dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_tag(head_tag), .head_reg_idx(head_reg_idx),
        .head_value(head_value), .head_npc(head_npc),
        .head_mispredict(head_mispredict), .head_halt(head_halt),
        .retire_ack(retire_ack), .mt_clear_en(mt_clear_en),
        .mt_clear_idx(mt_clear_idx), .mt_clear_tag(mt_clear_tag),
        .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .squash(squash), .redirect_pc(redirect_pc), .halted(halted),
        .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_head(input logic v, input logic [3:0] tag, input logic [4:0] idx,
                            input logic [31:0] val, input logic [31:0] npc,
                            input logic mp, input logic hlt);
        head_valid      = v;
        head_tag        = tag;
        head_reg_idx    = idx;
        head_value      = val;
        head_npc        = npc;
        head_mispredict = mp;
        head_halt       = hlt;
    endtask

    initial begin
        reset = 1'b1;
        set_head(1'b1, 4'd2, 5'd6, 32'h1111, 32'h40, 1'b0, 1'b0);
        #1;
        check("rst_ack",      {31'd0, retire_ack},  32'd0);
        check("rst_mtclr",    {31'd0, mt_clear_en}, 32'd0);
        check("rst_wr_en",    {31'd0, rf_wr_en},    32'd0);
        check("rst_squash",   {31'd0, squash},      32'd0);
        check("rst_halted",   {31'd0, halted},      32'd0);
        check("rst_count",    retired_count,        32'd0);
        check("rst_redirect", redirect_pc,          32'd0);
        @(negedge clock);
        @(negedge clock);
        check("rst_hold_cnt", retired_count, 32'd0);
        set_head(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Normal retire
        @(negedge clock);
        set_head(1'b1, 4'd3, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        #1;
        check("n_ack",      {31'd0, retire_ack},  32'd1);
        check("n_mtclr",    {31'd0, mt_clear_en}, 32'd1);
        check("n_mt_idx",   {27'd0, mt_clear_idx}, 32'd5);
        check("n_mt_tag",   {28'd0, mt_clear_tag}, 32'd3);
        @(negedge clock);
        set_head(1'b0, 4'd9, 5'd9, 32'h9999, 32'h0, 1'b0, 1'b0);
        check("n_wr_en",   {31'd0, rf_wr_en},  32'd1);
        check("n_wr_idx",  {27'd0, rf_wr_idx}, 32'd5);
        check("n_wr_data", rf_wr_data,         32'hDEADBEEF);
        check("n_count",   retired_count,      32'd1);
        #1;
        check("idle_ack",   {31'd0, retire_ack},  32'd0);
        check("idle_mtclr", {31'd0, mt_clear_en}, 32'd0);
        @(negedge clock);
        check("n_pulse",    {31'd0, rf_wr_en}, 32'd0);
        check("idle_count", retired_count,     32'd1);

        // x0 destination
        set_head(1'b1, 4'd4, 5'd0, 32'h1234, 32'h0, 1'b0, 1'b0);
        #1;
        check("x0_ack", {31'd0, retire_ack}, 32'd1);
        @(negedge clock);
        set_head(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("x0_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("x0_count", retired_count,     32'd2);

        // Mispredict with head_valid held high
        @(negedge clock);
        set_head(1'b1, 4'd5, 5'd7, 32'h55, 32'h100, 1'b1, 1'b0);
        #1;
        check("mp_ack", {31'd0, retire_ack}, 32'd1);
        @(negedge clock);
        set_head(1'b1, 4'd6, 5'd8, 32'h66, 32'h200, 1'b0, 1'b0);
        #1;
        check("mp_squash",   {31'd0, squash},     32'd1);
        check("mp_redirect", redirect_pc,         32'h100);
        check("mp_sq_ack",   {31'd0, retire_ack}, 32'd0);
        check("mp_sq_mtclr", {31'd0, mt_clear_en}, 32'd0);
        check("mp_wr_en",    {31'd0, rf_wr_en},   32'd1);
        check("mp_wr_idx",   {27'd0, rf_wr_idx},  32'd7);
        check("mp_count",    retired_count,       32'd3);
        @(negedge clock);
        #1;
        check("mp_sq_drop",  {31'd0, squash},     32'd0);
        check("mp_run_ack",  {31'd0, retire_ack}, 32'd1);
        check("mp_hold_pc",  redirect_pc,         32'h100);
        check("mp_cnt_hold", retired_count,       32'd3);
        set_head(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Counter wrap
        @(negedge clock);
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        check("wrap_pre", retired_count, 32'hFFFF_FFFF);
        set_head(1'b1, 4'd1, 5'd9, 32'hA5A5, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        set_head(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("wrap_count", retired_count, 32'd0);

        // Halt with simultaneous mispredict, then head_valid held for 5 cycles
        @(negedge clock);
        set_head(1'b1, 4'd2, 5'd4, 32'hAB, 32'h300, 1'b1, 1'b1);
        #1;
        check("h_ack", {31'd0, retire_ack}, 32'd1);
        @(negedge clock);
        set_head(1'b1, 4'd3, 5'd11, 32'hCD, 32'h400, 1'b0, 1'b0);
        check("h_halted",  {31'd0, halted},   32'd1);
        check("h_squash",  {31'd0, squash},   32'd0);
        check("h_wr_en",   {31'd0, rf_wr_en}, 32'd1);
        check("h_wr_data", rf_wr_data,        32'hAB);
        check("h_count",   retired_count,     32'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hh_ack",    {31'd0, retire_ack},  32'd0);
            check("hh_mtclr",  {31'd0, mt_clear_en}, 32'd0);
            @(negedge clock);
            check("hh_squash", {31'd0, squash},      32'd0);
            check("hh_wr_en",  {31'd0, rf_wr_en},    32'd0);
            check("hh_halted", {31'd0, halted},      32'd1);
            check("hh_count",  retired_count,        32'd1);
        end

        // Async reset leaves HALTED without a clock edge
        #2;
        reset = 1'b1;
        #1;
        check("hr_halted", {31'd0, halted}, 32'd0);
        check("hr_count",  retired_count,   32'd0);
        set_head(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Async reset mid-SQUASH
        @(negedge clock);
        set_head(1'b1, 4'd7, 5'd3, 32'h77, 32'h500, 1'b1, 1'b0);
        @(negedge clock);
        set_head(1'b1, 4'd8, 5'd2, 32'h88, 32'h0, 1'b0, 1'b0);
        check("ar_squash_pre", {31'd0, squash}, 32'd1);
        check("ar_pc_pre",     redirect_pc,     32'h500);
        #2;
        reset = 1'b1;
        #1;
        check("ar_squash",   {31'd0, squash},     32'd0);
        check("ar_halted",   {31'd0, halted},     32'd0);
        check("ar_redirect", redirect_pc,         32'd0);
        check("ar_wr_en",    {31'd0, rf_wr_en},   32'd0);
        check("ar_ack",      {31'd0, retire_ack}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("ar_post_ack", {31'd0, retire_ack}, 32'd1);
        @(negedge clock);
        set_head(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("ar_post_cnt",  retired_count,      32'd1);
        check("ar_post_wr",   {31'd0, rf_wr_en},  32'd1);
        check("ar_post_data", rf_wr_data,         32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
